// File: rtl/ddr_access_ctrl_if.sv
// ddr_access_ctrl_if: processor request/response and memory port bundle.
// slave = controller side, master = processor/memory environment side.
interface ddr_access_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [18:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [7:0]  last_lat;
  logic [7:0]  err_count;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        mem_rdy_we;
  logic        mem_rdy_re;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  mem_rdata, mem_rdy_we, mem_rdy_re,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output last_lat, err_count,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output mem_rdata, mem_rdy_we, mem_rdy_re,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  last_lat, err_count,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/ddr_access_ctrl.sv
// ddr_access_ctrl: single-outstanding DDR image memory initiator.
// Latches one request, waits for ready or timeout, returns a response.
module ddr_access_ctrl #(
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned MIN_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  ddr_access_ctrl_if.slave  bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] MW    = 8'(MIN_WAIT);
  localparam logic [7:0] TO    = 8'(TIMEOUT);
  localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic        op_we_q, op_we_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  last_lat_q, last_lat_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [18:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        rdy;

  // Ready strobe matching the latched op; the other strobe is ignored.
  assign rdy = op_we_q ? bus.mem_rdy_we : bus.mem_rdy_re;

  // Next-state and response logic.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    op_we_d     = op_we_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    last_lat_d  = last_lat_q;
    err_count_d = err_count_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          mem_addr_d  = bus.req_addr;
          mem_wdata_d = bus.req_wdata;
          mem_we_d    = bus.req_we;
          op_we_d     = bus.req_we;
          timer_d     = 8'd0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (rdy && timer_q >= MW) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = op_we_q ? 8'd0 : bus.mem_rdata;
          last_lat_d  = timer_q + 8'd1;
          state_d     = IDLE;
        end else if (timer_q == TO_M1) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 8'd0;
          last_lat_d  = TO;
          if (err_count_q != 8'hFF)
            err_count_d = err_count_q + 8'd1;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= 8'd0;
      op_we_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'd0;
      rsp_err_q   <= 1'b0;
      last_lat_q  <= 8'd0;
      err_count_q <= 8'd0;
      mem_addr_q  <= 19'd0;
      mem_wdata_q <= 8'd0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      op_we_q     <= op_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      last_lat_q  <= last_lat_d;
      err_count_q <= err_count_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.last_lat  = last_lat_q;
  assign bus.err_count = err_count_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;

endmodule

// File: tb/tb_ddr_access_ctrl.sv
// tb_ddr_access_ctrl: directed and random transactions checked
// against a per-transaction model of completion latency and result.
module tb_ddr_access_ctrl;

  localparam int TO = 64;
  localparam int MW = 1;
  localparam int PW = TO + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_ec = 0;

  ddr_access_ctrl_if bus();

  ddr_access_ctrl #(.TIMEOUT(TO), .MIN_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic set_strb(input logic we,
                          input logic q,
                          input logic o);
    bus.mem_rdy_we = we ? q : o;
    bus.mem_rdy_re = we ? o : q;
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    set_strb(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle_rsp", bus.rsp_valid, 0);
      chk("idle_rdy", bus.req_ready, 1);
    end
  endtask

  // qp[j]: qualifying strobe level sampled on edge accept+j.
  // op[j]: level of the other strobe on the same edge.
  task automatic run_txn(input logic we,
                         input logic [18:0] a,
                         input logic [7:0] wd,
                         input logic [7:0] rd,
                         input logic [PW-1:0] qp,
                         input logic [PW-1:0] op);
    int done;
    logic err;
    logic [7:0] exp_rd;
    done = 0;
    for (int j = MW + 1; j <= TO; j++)
      if (done == 0 && qp[j]) done = j;
    err = (done == 0);
    if (err) done = TO;
    exp_rd = (err || we) ? 8'd0 : rd;

    chk("pre_rdy", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.mem_rdata = 8'($urandom);
    set_strb(we, qp[0], op[0]);
    @(posedge clk); #1;
    chk("acc_we", bus.mem_we, we);
    chk("acc_addr", bus.mem_addr, a);
    chk("acc_wdata", bus.mem_wdata, wd);
    chk("acc_rdy", bus.req_ready, 0);
    chk("acc_rsp", bus.rsp_valid, 0);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = 19'($urandom);
    bus.req_wdata = 8'($urandom);

    for (int j = 1; j <= done; j++) begin
      set_strb(we, qp[j], op[j]);
      bus.mem_rdata = qp[j] ? rd : 8'($urandom);
      @(posedge clk); #1;
      if (j < done) begin
        chk("wait_rsp", bus.rsp_valid, 0);
        chk("wait_we", bus.mem_we, 0);
      end
    end

    if (err && exp_ec < 255) exp_ec++;
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_err", bus.rsp_err, err);
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("last_lat", bus.last_lat, done);
    chk("err_count", bus.err_count, exp_ec);
    chk("rsp_rdy", bus.req_ready, 1);
    chk("hold_addr", bus.mem_addr, a);
    chk("hold_wdata", bus.mem_wdata, wd);
    chk("rsp_we", bus.mem_we, 0);
    set_strb(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [PW-1:0] qp;
    logic [PW-1:0] op;
    logic we;
    int k;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_rdata  = '0;
    bus.mem_rdy_we = 1'b0;
    bus.mem_rdy_re = 1'b0;
    #3;
    chk("rst_rdy", bus.req_ready, 1);
    chk("rst_rsp", bus.rsp_valid, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_ec", bus.err_count, 0);
    chk("rst_lat", bus.last_lat, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    qp = '0; qp[7] = 1'b1;
    run_txn(1'b1, 19'h00003, 8'hA0, 8'h00, qp, '0);
    qp = '0; qp[3] = 1'b1;
    run_txn(1'b0, 19'h00003, 8'h00, 8'hA0, qp, '0);
    qp = '0; qp[0] = 1'b1; qp[1] = 1'b1; qp[5] = 1'b1;
    run_txn(1'b0, 19'h00003, 8'h00, 8'h5C, qp, '0);
    idle(1);
    qp = '0; op = '1;
    run_txn(1'b1, 19'h7FFFF, 8'h3C, 8'h00, qp, op);
    qp = '0; qp[TO] = 1'b1;
    run_txn(1'b0, 19'h12345, 8'h00, 8'hE7, qp, '0);
    qp = '0; qp[MW + 1] = 1'b1;
    run_txn(1'b1, 19'h00001, 8'h11, 8'h00, qp, '0);

    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 19'h0ABCD;
    bus.req_wdata = 8'h77;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mrst_we", bus.mem_we, 0);
    chk("mrst_addr", bus.mem_addr, 0);
    chk("mrst_rdy", bus.req_ready, 1);
    chk("mrst_rsp", bus.rsp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ec = 0;
    bus.mem_rdy_we = 1'b1;
    @(posedge clk); #1;
    chk("mrst_norsp", bus.rsp_valid, 0);
    chk("mrst_ec", bus.err_count, 0);
    chk("mrst_lat", bus.last_lat, 0);
    idle(2);
    qp = '0; qp[4] = 1'b1;
    run_txn(1'b0, 19'h00011, 8'h00, 8'h9B, qp, '0);

    for (int t = 0; t < 150; t++) begin
      we = 1'($urandom);
      op = '0;
      qp = '0;
      for (int j = 0; j < PW; j++)
        op[j] = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        k = $urandom_range(1, TO + 1);
        qp[k] = 1'b1;
        for (int j = 0; j <= MW; j++)
          qp[j] = 1'($urandom);
      end else begin
        for (int j = 0; j < PW; j++)
          qp[j] = ($urandom_range(0, 15) == 0);
      end
      run_txn(we, 19'($urandom), 8'($urandom),
              8'($urandom), qp, op);
      if ($urandom_range(0, 2) != 0)
        idle($urandom_range(1, 2));
    end

    for (int t = 0; t < 300; t++)
      run_txn(1'($urandom), 19'($urandom), 8'($urandom),
              8'($urandom), '0, '0);
    chk("ec_sat", bus.err_count, 255);
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_access_ctrl.md
# ddr_access_ctrl

Single-outstanding-transaction initiator that drives the byte-wide DDR image memory port (19-bit address, 8-bit data, write-enable, separate write/read ready strobes) on behalf of the processor datapath. It latches one processor request, presents the address, data and write-enable to the memory, and waits for the matching ready strobe or a timeout. It then returns a one-cycle response carrying read data, an error flag and the measured latency. It sits between the processor load/store unit and port A of the DDR image memory.

## Interface
- TIMEOUT, 64: wait-cycle limit; legal range 2..255.
- MIN_WAIT, 1: wait cycles during which ready is ignored (masks stale ready from the previous access); must be < TIMEOUT.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  processor request present.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  19  byte address.
- req_wdata  in  8  write data.
- req_ready  out  1  controller idle; request accepted on an edge where req_valid & req_ready.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read data; 0 for writes and timeouts.
- rsp_err  out  1  completion was a timeout; qualified by rsp_valid.
- last_lat  out  8  wait cycles of the most recent completion.
- err_count  out  8  timeouts since reset, saturating at 255.
- mem_addr  out  19  memory address; held stable between requests.
- mem_wdata  out  8  memory write data.
- mem_we  out  1  memory write-enable; exactly one cycle per write.
- mem_rdata  in  8  memory read data (memory q output).
- mem_rdy_we  in  1  memory write-complete strobe.
- mem_rdy_re  in  1  memory read-complete strobe.

## Operation
- States: IDLE, WAIT.
- Reset values: state IDLE; req_ready 1; rsp_valid 0; rsp_rdata 0; rsp_err 0; last_lat 0; err_count 0; mem_addr 0; mem_wdata 0; mem_we 0; timer 0.
- req_ready = (state == IDLE), combinational from state.
- IDLE, accepting edge:
  - Register mem_addr = req_addr, mem_wdata = req_wdata, mem_we = req_we.
  - Latch the op type; timer = 0; go to WAIT.
- WAIT, every edge:
  - mem_we = 0.
  - Qualifying ready is mem_rdy_we for a write or mem_rdy_re for a read, sampled only when timer >= MIN_WAIT. The other strobe is ignored.
  - Qualifying ready present: rsp_valid = 1, rsp_err = 0, rsp_rdata = mem_rdata for a read (0 for a write), last_lat = timer+1; go to IDLE.
  - Otherwise, if timer == TIMEOUT-1: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, last_lat = TIMEOUT, err_count += 1 (saturating); go to IDLE.
  - Otherwise timer += 1.
  - Ready and timeout on the same edge: ready wins, no error.
- rsp_valid is cleared on the edge after it is set, unless a new completion occurs on that edge.
- mem_addr and mem_wdata keep their values after completion until the next accept, so the memory sees no spurious address change.
- A request arriving while in WAIT stalls: req_ready = 0, nothing latched, and req_* must be held by the requester.
- Reset asserted mid-transaction: all outputs take reset values immediately, including mem_we = 0 and mem_addr = 0. The in-flight transaction is dropped with no response.
- Timer is 8 bits and never wraps, because TIMEOUT <= 255.

## Timing
- Accept on edge N:
  - mem_we is high from edge N to edge N+1 for writes.
  - The first ready sample occurs at edge N+1+MIN_WAIT.
- Ready seen at WAIT edge E: rsp_valid is high for the cycle after E, and req_ready is high in that same cycle.
- Back-to-back: a new request can be accepted on edge E+1, while rsp_valid is high. Minimum spacing between accepts is 1+MIN_WAIT+1 edges.
- No response: rsp_valid rises after edge N+TIMEOUT.
- Read data is sampled from mem_rdata on the completing edge. The memory must present valid q no later than its ready strobe.

## Test plan
- Reset, then idle: req_ready=1, rsp_valid=0, mem_we=0, mem_addr=0, err_count=0.
- Write to addr 0x00003, data 0xA0; bench pulses mem_rdy_we 7 cycles after mem_we:
  - mem_we is high for exactly 1 cycle, with mem_addr=0x00003 and mem_wdata=0xA0.
  - Response: rsp_valid 1 cycle, rsp_err=0, rsp_rdata=0x00, last_lat=7.
- Read from addr 0x00003; bench drives mem_rdata=0xA0 with mem_rdy_re 3 cycles after accept: rsp_rdata=0xA0, rsp_err=0, last_lat=3, mem_we stays 0.
- Stale ready: mem_rdy_re held high during the cycle of accept and the first WAIT cycle with MIN_WAIT=1, then low; bench pulses mem_rdy_re again 5 cycles later: completion occurs on the later pulse only, with last_lat=5.
- No ready with TIMEOUT=64: rsp_valid one cycle after 64 wait cycles, rsp_err=1, rsp_rdata=0, last_lat=64, err_count=1. 300 timeouts leave err_count=255.
- Reset asserted 2 cycles into a write wait:
  - Immediately: mem_we=0, mem_addr=0, req_ready=1.
  - No rsp_valid.
  - A subsequent read to 0x00011 completes normally.
